clkdiv_prog: RTL and testbench
==============================

# clkdiv_prog

Multi-channel programmable clock divider, the parametrised successor to the fixed divide-by-8 counter divider. Each of NCH channels divides the single system clock by a run-time programmable integer ratio and produces two registered outputs: a near-50% duty divided level for clock-buffer or pin use, and a one-cycle tick clock-enable for logic that stays in the system clock domain. Ratio changes are staged and take effect only at a period boundary, so every output period is whole and glitch-free. The block sits at the top level beside the clock-management logic and feeds per-subsystem clock enables.

## Interface
- NCH, 4: number of channels, 1..16.
- WIDTH, 8: divisor and counter width in bits.
- RESET_DIV, 8: divisor loaded into every channel on reset; must be in 2..2^WIDTH-1.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  write strobe for one channel's divisor.
- cfg_ch  in  clog2(NCH) (min 1)  channel index for the write; indices >= NCH are ignored.
- cfg_div  in  WIDTH  requested divisor; values 0 and 1 are stored as 2.
- ch_en  in  NCH  per-channel run enable.
- sync  in  1  one-cycle pulse that restarts the phase of all channels together.
- pending  out  NCH  bit i high while channel i holds a staged divisor not yet applied.
- tick  out  NCH  one-cycle pulse per channel period.
- clk_out  out  NCH  divided level per channel.

## Operation
- Per-channel state: cnt[WIDTH], active divisor div, shadow divisor, pending flag, registered tick and clk_out.
- Reset (async): cnt=0, div=shadow=RESET_DIV, pending=0, tick=0, clk_out=0 on all channels.
- Counting (ch_en[i]=1, no sync): cnt <= (cnt==div-1) ? 0 : cnt+1. The cnt==div-1 cycle is the wrap.
- Let H = div - (div>>1). Registered outputs track the new count: clk_out=1 exactly while cnt >= H, giving floor(div/2) cycles high and ceil(div/2) low. tick=1 exactly in the cycle after a wrap, when cnt is 0.
- Configuration: cfg_we with a valid cfg_ch writes the clamped value to that channel's shadow and sets pending. A second write while pending overwrites the shadow; only the last value is applied.
- Apply: at a wrap with pending set, div <= shadow and pending clears. The new H and period start from the cnt=0 that follows.
- A write in the same cycle as that channel's wrap applies the written value directly at this wrap; pending stays 0.
- Disabled (ch_en[i]=0): cnt forced to 0, clk_out=0, tick=0. Any staged divisor, or a same-cycle write, is applied at once and pending clears. On re-enable the channel starts its phase from cnt=0, with the first tick after div enabled cycles.
- sync: every channel is forced to cnt=0, clk_out=0, tick=0, and staged divisors are applied. Channels enabled during the following cycles stay phase-aligned for equal divisors.
- Priority per channel: rst > sync > ch_en=0 > wrap/apply > count.

## Timing
- All outputs are registered and change only on clk rising edges or asynchronously on rst. No combinational path from any input to any output.
- cfg write to pending: pending is high from the cycle after cfg_we. It clears the cycle after the wrap that applies the value.
- First tick after reset release with ch_en high: the cycle following the div-th enabled edge. Subsequent ticks follow exactly every div cycles.
- Divisor change latency: between 1 and old div cycles (the remainder of the current period). There are no partial or shortened periods.
- Counter arithmetic is unsigned WIDTH-bit; cnt never exceeds div-1, so no wrap-around beyond div is possible.
- Maximum divisor is 2^WIDTH-1.

## Test plan
- Reset, ch_en=all 1, RESET_DIV=8 -> each clk_out is low for 4 cycles and high for 4. Each tick appears once per 8 cycles, first at cycle 8 after reset release.
- cfg_we ch1 div=3 mid-period -> pending[1]=1 until ch1's next wrap. ch1 then runs period 3 (1 high, 2 low) with no short period. Other channels are unaffected.
- cfg_div=0 and cfg_div=1 -> both stored as 2: clk_out toggles every cycle and tick fires every 2 cycles. cfg_ch=NCH -> no state change.
- Two writes to ch0 (5 then 6) before the wrap, then a write to ch2 in its wrap cycle -> ch0 applies only 6. ch2 applies its value at that wrap with pending[2] never set.
- ch_en[3] dropped while pending, then raised -> pending clears immediately and outputs are 0 while disabled. After re-enable, the first tick comes after the new div cycles.
- sync pulse with channels at different phases, all div=4 -> the next ticks coincide on all channels. Assert rst mid-period -> outputs are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/clkdiv_prog.sv
// clkdiv_prog: multi-channel programmable clock divider with staged divisor updates.
// Each channel emits a near-50% divided level and a one-cycle tick clock-enable.
module clkdiv_prog #(
    parameter int NCH       = 4,
    parameter int WIDTH     = 8,
    parameter int RESET_DIV = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     cfg_we,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
    input  logic [WIDTH-1:0]                         cfg_div,
    input  logic [NCH-1:0]                           ch_en,
    input  logic                                     sync,
    output logic [NCH-1:0]                           pending,
    output logic [NCH-1:0]                           tick,
    output logic [NCH-1:0]                           clk_out
);
    localparam int               CHW      = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [WIDTH-1:0] DIV_INIT = WIDTH'(RESET_DIV);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO      = WIDTH'(2);

    logic [WIDTH-1:0] cfg_val;
    logic             cfg_valid;

    // Divisors below 2 cannot produce a meaningful period, so they are raised to 2.
    assign cfg_val   = (cfg_div < TWO) ? TWO : cfg_div;
    assign cfg_valid = cfg_we && (int'(cfg_ch) < NCH);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] div;
        logic [WIDTH-1:0] shadow;
        logic [WIDTH-1:0] half;
        logic [WIDTH-1:0] cnt_inc;
        logic [WIDTH-1:0] div_next;
        logic             pend;
        logic             tick_r;
        logic             clk_r;
        logic             wr;
        logic             wrap;

        assign wr      = cfg_valid && (cfg_ch == CHW'(i));
        assign half    = div - (div >> 1);
        assign wrap    = (cnt == div - ONE);
        assign cnt_inc = cnt + ONE;
        // A write landing on an apply point wins over an older staged value.
        assign div_next = wr ? cfg_val : (pend ? shadow : div);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt    <= '0;
                div    <= DIV_INIT;
                shadow <= DIV_INIT;
                pend   <= 1'b0;
                tick_r <= 1'b0;
                clk_r  <= 1'b0;
            end else if (sync || !ch_en[i]) begin
                cnt    <= '0;
                div    <= div_next;
                shadow <= div_next;
                pend   <= 1'b0;
                tick_r <= 1'b0;
                clk_r  <= 1'b0;
            end else if (wrap) begin
                cnt    <= '0;
                div    <= div_next;
                shadow <= div_next;
                pend   <= 1'b0;
                tick_r <= 1'b1;
                clk_r  <= 1'b0;
            end else begin
                cnt    <= cnt_inc;
                tick_r <= 1'b0;
                clk_r  <= (cnt_inc >= half);
                if (wr) begin
                    shadow <= cfg_val;
                    pend   <= 1'b1;
                end
            end
        end

        assign pending[i] = pend;
        assign tick[i]    = tick_r;
        assign clk_out[i] = clk_r;
    end
endmodule

// File: tb/tb_clkdiv_prog.sv
// tb_clkdiv_prog: randomized and directed checks of clkdiv_prog against a
// period-level reference model (phase within period, staged divisor).
module tb_clkdiv_prog;
    localparam int NCH       = 5;
    localparam int WIDTH     = 8;
    localparam int RESET_DIV = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_we;
    logic [2:0]       cfg_ch;
    logic [WIDTH-1:0] cfg_div;
    logic [NCH-1:0]   ch_en;
    logic             sync;
    logic [NCH-1:0]   pending;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   clk_out;

    int checks   = 0;
    int failures = 0;

    // Reference model: active divisor, position inside the current period,
    // staged divisor (-1 when nothing is staged).
    int             m_div    [NCH];
    int             m_phase  [NCH];
    int             m_staged [NCH];
    logic [NCH-1:0] exp_pend;
    logic [NCH-1:0] exp_tick;
    logic [NCH-1:0] exp_clk;

    clkdiv_prog #(.NCH(NCH), .WIDTH(WIDTH), .RESET_DIV(RESET_DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .ch_en   (ch_en),
        .sync    (sync),
        .pending (pending),
        .tick    (tick),
        .clk_out (clk_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_div[c]    = RESET_DIV;
            m_phase[c]  = 0;
            m_staged[c] = -1;
        end
        exp_pend = '0;
        exp_tick = '0;
        exp_clk  = '0;
    endtask

    // One rising edge of the model, using the inputs currently applied.
    task automatic model_step();
        int val;
        val = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
        for (int c = 0; c < NCH; c++) begin
            if (cfg_we && int'(cfg_ch) == c)
                m_staged[c] = val;
            if (sync || !ch_en[c]) begin
                if (m_staged[c] >= 0) begin
                    m_div[c]    = m_staged[c];
                    m_staged[c] = -1;
                end
                m_phase[c]  = 0;
                exp_tick[c] = 1'b0;
                exp_clk[c]  = 1'b0;
            end else if (m_phase[c] == m_div[c] - 1) begin
                if (m_staged[c] >= 0) begin
                    m_div[c]    = m_staged[c];
                    m_staged[c] = -1;
                end
                m_phase[c]  = 0;
                exp_tick[c] = 1'b1;
                exp_clk[c]  = 1'b0;
            end else begin
                m_phase[c]  = m_phase[c] + 1;
                exp_tick[c] = 1'b0;
                // Low for the first ceil(div/2) positions, high for the rest.
                exp_clk[c]  = (m_phase[c] >= (m_div[c] + 1) / 2);
            end
            exp_pend[c] = (m_staged[c] >= 0);
        end
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; ch_en = '0; sync = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({pending, tick, clk_out} !== '0) begin
                failures++;
                $display("[TB] FAIL reset_state: pending/tick/clk_out=%b/%b/%b required all zero",
                         pending, tick, clk_out);
            end
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_default_period();
        int first_tick = 0;
        int highs      = 0;
        ch_en = '1;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            advance();
            checks++;
            if ({pending, tick, clk_out} !== {exp_pend, exp_tick, exp_clk}) begin
                failures++;
                $display("[TB] FAIL default_period cyc %0d: got %b/%b/%b expected %b/%b/%b",
                         cyc, pending, tick, clk_out, exp_pend, exp_tick, exp_clk);
            end
            if (tick[0] && first_tick == 0) first_tick = cyc;
            if (cyc <= 16 && clk_out[0]) highs++;
        end
        checks++;
        if (first_tick != 8) begin
            failures++;
            $display("[TB] FAIL first_tick: got cycle %0d expected 8", first_tick);
        end
        checks++;
        if (highs != 8) begin
            failures++;
            $display("[TB] FAIL duty_div8: high cycles in 16 got %0d expected 8", highs);
        end
    endtask

    task automatic test_cfg_mid();
        int last_t = -1;
        int prev_t = -1;
        for (int k = 0; k < 2; k++) advance();
        cfg_we = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd3;
        advance();
        cfg_we = 1'b0;
        checks++;
        if (pending[1] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL cfg_mid_pending: pending[1]=%b expected 1", pending[1]);
        end
        for (int k = 0; k < 20; k++) begin
            advance();
            checks++;
            if ({pending, tick, clk_out} !== {exp_pend, exp_tick, exp_clk}) begin
                failures++;
                $display("[TB] FAIL cfg_mid cyc %0d: got %b/%b/%b expected %b/%b/%b",
                         k, pending, tick, clk_out, exp_pend, exp_tick, exp_clk);
            end
            if (tick[1]) begin prev_t = last_t; last_t = k; end
        end
        checks++;
        if (last_t - prev_t != 3 || prev_t < 0) begin
            failures++;
            $display("[TB] FAIL cfg_mid_period: ch1 tick spacing got %0d expected 3", last_t - prev_t);
        end
    endtask

    task automatic test_clamp();
        int ticks0 = 0;
        logic [2:0] chs  [4] = '{3'd0, 3'd2, 3'd5, 3'd7};
        logic [7:0] divs [4] = '{8'd0, 8'd1, 8'd9, 8'd9};
        for (int k = 0; k < 4; k++) begin
            cfg_we = 1'b1; cfg_ch = chs[k]; cfg_div = divs[k];
            advance();
            checks++;
            if ({pending, tick, clk_out} !== {exp_pend, exp_tick, exp_clk}) begin
                failures++;
                $display("[TB] FAIL clamp_write %0d: got %b/%b/%b expected %b/%b/%b",
                         k, pending, tick, clk_out, exp_pend, exp_tick, exp_clk);
            end
        end
        cfg_we = 1'b0;
        for (int k = 0; k < 30; k++) begin
            advance();
            checks++;
            if ({pending, tick, clk_out} !== {exp_pend, exp_tick, exp_clk}) begin
                failures++;
                $display("[TB] FAIL clamp cyc %0d: got %b/%b/%b expected %b/%b/%b",
                         k, pending, tick, clk_out, exp_pend, exp_tick, exp_clk);
            end
            if (k >= 20 && tick[0]) ticks0++;
        end
        checks++;
        if (ticks0 != 5) begin
            failures++;
            $display("[TB] FAIL clamp_div2: ch0 ticks in 10 cycles got %0d expected 5", ticks0);
        end
    endtask

    task automatic test_overwrite();
        int  last_t = -1;
        int  prev_t = -1;
        bit  pend2_seen = 1'b0;
        cfg_we = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd8;
        advance();
        cfg_we = 1'b0;
        for (int k = 0; k < 40 && !(m_staged[0] < 0 && m_phase[0] == 1); k++) advance();
        checks++;
        if (!(m_staged[0] < 0 && m_phase[0] == 1)) begin
            failures++;
            $display("[TB] FAIL overwrite_setup: timeout waiting for ch0 phase 1");
        end
        cfg_we = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd5;
        advance();
        cfg_div = 8'd6;
        advance();
        cfg_we = 1'b0;
        for (int k = 0; k < 30; k++) begin
            advance();
            checks++;
            if ({pending, tick, clk_out} !== {exp_pend, exp_tick, exp_clk}) begin
                failures++;
                $display("[TB] FAIL overwrite cyc %0d: got %b/%b/%b expected %b/%b/%b",
                         k, pending, tick, clk_out, exp_pend, exp_tick, exp_clk);
            end
            if (tick[0]) begin prev_t = last_t; last_t = k; end
        end
        checks++;
        if (last_t - prev_t != 6 || prev_t < 0) begin
            failures++;
            $display("[TB] FAIL overwrite_last_wins: ch0 tick spacing got %0d expected 6", last_t - prev_t);
        end
        // Same-cycle write at ch2's wrap must apply directly.
        for (int k = 0; k < 20 && m_phase[2] != m_div[2] - 1; k++) advance();
        cfg_we = 1'b1; cfg_ch = 3'd2; cfg_div = 8'd7;
        advance();
        cfg_we = 1'b0;
        last_t = -1; prev_t = -1;
        for (int k = 0; k < 20; k++) begin
            if (pending[2]) pend2_seen = 1'b1;
            if (tick[2]) begin prev_t = last_t; last_t = k; end
            checks++;
            if ({pending, tick, clk_out} !== {exp_pend, exp_tick, exp_clk}) begin
                failures++;
                $display("[TB] FAIL wrap_write cyc %0d: got %b/%b/%b expected %b/%b/%b",
                         k, pending, tick, clk_out, exp_pend, exp_tick, exp_clk);
            end
            advance();
        end
        checks++;
        if (pend2_seen) begin
            failures++;
            $display("[TB] FAIL wrap_write_pending: pending[2] got 1 expected never set");
        end
        checks++;
        if (last_t - prev_t != 7 || prev_t < 0) begin
            failures++;
            $display("[TB] FAIL wrap_write_period: ch2 tick spacing got %0d expected 7", last_t - prev_t);
        end
    endtask

    task automatic test_disable();
        int first = -1;
        for (int k = 0; k < 20 && m_phase[3] == m_div[3] - 1; k++) advance();
        cfg_we = 1'b1; cfg_ch = 3'd3; cfg_div = 8'd5;
        advance();
        cfg_we = 1'b0;
        checks++;
        if (pending[3] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL disable_setup: pending[3]=%b expected 1", pending[3]);
        end
        ch_en[3] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            advance();
            checks++;
            if ({pending[3], tick[3], clk_out[3]} !== 3'b000) begin
                failures++;
                $display("[TB] FAIL disabled cyc %0d: ch3 pending/tick/clk_out=%b%b%b expected 000",
                         k, pending[3], tick[3], clk_out[3]);
            end
        end
        ch_en[3] = 1'b1;
        for (int k = 1; k <= 20 && first < 0; k++) begin
            advance();
            checks++;
            if ({pending, tick, clk_out} !== {exp_pend, exp_tick, exp_clk}) begin
                failures++;
                $display("[TB] FAIL reenable cyc %0d: got %b/%b/%b expected %b/%b/%b",
                         k, pending, tick, clk_out, exp_pend, exp_tick, exp_clk);
            end
            if (tick[3]) first = k;
        end
        checks++;
        if (first != 5) begin
            failures++;
            $display("[TB] FAIL reenable_first_tick: got cycle %0d expected 5", first);
        end
    endtask

    task automatic test_sync();
        for (int c = 0; c < NCH; c++) begin
            cfg_we = 1'b1; cfg_ch = 3'(c); cfg_div = 8'd4;
            advance();
        end
        cfg_we = 1'b0;
        for (int k = 0; k < 3; k++) advance();
        sync = 1'b1;
        advance();
        sync = 1'b0;
        for (int k = 0; k < 12; k++) begin
            advance();
            checks++;
            if ({pending, tick, clk_out} !== {exp_pend, exp_tick, exp_clk}) begin
                failures++;
                $display("[TB] FAIL sync cyc %0d: got %b/%b/%b expected %b/%b/%b",
                         k, pending, tick, clk_out, exp_pend, exp_tick, exp_clk);
            end
            if (k == 3) begin
                checks++;
                if (tick !== {NCH{1'b1}}) begin
                    failures++;
                    $display("[TB] FAIL sync_aligned: tick=%b expected all ones", tick);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            cfg_we  = ($urandom % 4) == 0;
            cfg_ch  = 3'($urandom % 8);
            cfg_div = ($urandom % 3 == 0) ? 8'($urandom % 4) : 8'($urandom % 12);
            sync    = ($urandom % 64) == 0;
            if ($urandom % 16 == 0) ch_en[$urandom % NCH] ^= 1'b1;
            advance();
            checks++;
            if ({pending, tick, clk_out} !== {exp_pend, exp_tick, exp_clk}) begin
                failures++;
                $display("[TB] FAIL random cyc %0d: got %b/%b/%b expected %b/%b/%b",
                         k, pending, tick, clk_out, exp_pend, exp_tick, exp_clk);
            end
        end
        cfg_we = 1'b0; sync = 1'b0; ch_en = '1;
    endtask

    task automatic test_async_reset();
        cfg_we = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd9;
        advance();
        cfg_we = 1'b0;
        for (int k = 0; k < 3; k++) advance();
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({pending, tick, clk_out} !== '0) begin
            failures++;
            $display("[TB] FAIL async_reset: pending/tick/clk_out=%b/%b/%b required all zero",
                     pending, tick, clk_out);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 10; k++) begin
            advance();
            checks++;
            if ({pending, tick, clk_out} !== {exp_pend, exp_tick, exp_clk}) begin
                failures++;
                $display("[TB] FAIL post_reset cyc %0d: got %b/%b/%b expected %b/%b/%b",
                         k, pending, tick, clk_out, exp_pend, exp_tick, exp_clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_period();
        test_cfg_mid();
        test_clamp();
        test_overwrite();
        test_disable();
        test_sync();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
